// File: rtl/iommu_ddtc_sa_if.sv
// iommu_ddtc_sa_if: lookup, fill and invalidate signals of the set-associative DDTC.
// slave = the cache itself, master = translation wrapper / DDT walker side.
interface iommu_ddtc_sa_if #(
    parameter int DID_WIDTH = 24,
    parameter int DC_WIDTH  = 512
);
    logic                 lookup_valid_i;
    logic                 lookup_ready_o;
    logic [DID_WIDTH-1:0] lu_did_i;
    logic                 lu_valid_o;
    logic                 lu_hit_o;
    logic [DC_WIDTH-1:0]  lu_content_o;
    logic                 update_i;
    logic [DID_WIDTH-1:0] up_did_i;
    logic [DC_WIDTH-1:0]  up_content_i;
    logic                 up_dc_v_i;
    logic                 flush_i;
    logic                 flush_dv_i;
    logic [DID_WIDTH-1:0] flush_did_i;
    logic                 flush_busy_o;

    modport slave (
        input  lookup_valid_i, lu_did_i, update_i, up_did_i, up_content_i, up_dc_v_i,
               flush_i, flush_dv_i, flush_did_i,
        output lookup_ready_o, lu_valid_o, lu_hit_o, lu_content_o, flush_busy_o
    );

    modport master (
        output lookup_valid_i, lu_did_i, update_i, up_did_i, up_content_i, up_dc_v_i,
               flush_i, flush_dv_i, flush_did_i,
        input  lookup_ready_o, lu_valid_o, lu_hit_o, lu_content_o, flush_busy_o
    );
endinterface

// File: rtl/iommu_ddtc_sa.sv
// iommu_ddtc_sa: set-associative Device Directory Table Cache with one tree-PLRU per set.
// Registered lookup response, single-cycle per-DID invalidate, multi-cycle invalidate-all walk.
// Build macro IOMMU_DDTC_PERF_CNT_EN adds saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module iommu_ddtc_sa #(
    parameter int DID_WIDTH = 24,
    parameter int DC_WIDTH  = 512,
    parameter int SETS      = 4,
    parameter int WAYS      = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    iommu_ddtc_sa_if.slave bus
`ifdef IOMMU_DDTC_PERF_CNT_EN
    ,
    output logic [31:0]    hit_cnt_o,
    output logic [31:0]    miss_cnt_o
`endif
);
    localparam int SET_BITS = $clog2(SETS);
    localparam int IDX_W    = (SET_BITS == 0) ? 1 : SET_BITS;
    localparam int TAG_W    = DID_WIDTH - SET_BITS;
    localparam int WAY_W    = $clog2(WAYS);
    localparam int NODES    = WAYS - 1;

    typedef logic [DID_WIDTH-1:0] did_t;
    typedef logic [IDX_W-1:0]     idx_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [WAY_W-1:0]     way_t;
    typedef logic [NODES-1:0]     tree_t;
    typedef logic [WAYS-1:0]      wvec_t;

    typedef enum logic {IDLE, WALK} state_e;

    function automatic idx_t set_of(input did_t did);
        return idx_t'(did & did_t'(SETS - 1));
    endfunction

    function automatic tag_t tag_of(input did_t did);
        return tag_t'(did >> SET_BITS);
    endfunction

    // One-hot to binary; callers guarantee at most one bit set
    function automatic way_t enc(input wvec_t v);
        way_t r;
        r = '0;
        for (int w = 0; w < WAYS; w++)
            if (v[w]) r = r | way_t'(w);
        return r;
    endfunction

    // Heap-ordered tree (root 0, children 2n+1/2n+2); level l is steered by way bit l.
    // Each node on the path is set to ~(way bit) so it points away from the touched way.
    function automatic tree_t plru_touch(input tree_t tree, input way_t way);
        tree_t t;
        way_t  n;
        t = tree;
        n = '0;
        for (int l = 0; l < WAY_W; l++) begin
            t[n] = ~way[l];
            n    = (n << 1) + way_t'(1) + way_t'(way[l]);
        end
        return t;
    endfunction

    // Follow the node bits from the root; they spell the victim's way bits LSB first
    function automatic way_t plru_victim(input tree_t tree);
        way_t v;
        way_t n;
        v = '0;
        n = '0;
        for (int l = 0; l < WAY_W; l++) begin
            v[l] = tree[n];
            n    = (n << 1) + way_t'(1) + way_t'(tree[n]);
        end
        return v;
    endfunction

    state_e              state_q, state_d;
    idx_t                cnt_q, cnt_d;
    wvec_t [SETS-1:0]    valid_q, valid_d;
    tree_t [SETS-1:0]    plru_q, plru_d;
    tag_t                tag_q  [SETS][WAYS];
    logic [DC_WIDTH-1:0] data_q [SETS][WAYS];

    logic                lu_valid_q, lu_valid_d;
    logic                lu_hit_q, lu_hit_d;
    logic [DC_WIDTH-1:0] lu_content_q, lu_content_d;

    idx_t  lu_set, up_set, fl_set;
    tag_t  lu_tag, up_tag, fl_tag;
    wvec_t lu_hit_vec, up_match_vec, fl_match_vec;
    way_t  lu_hit_way, free_way, fill_way;
    logic  free_found, busy, ready, lu_accept, fill_en;

    assign lu_set = set_of(bus.lu_did_i);
    assign up_set = set_of(bus.up_did_i);
    assign fl_set = set_of(bus.flush_did_i);
    assign lu_tag = tag_of(bus.lu_did_i);
    assign up_tag = tag_of(bus.up_did_i);
    assign fl_tag = tag_of(bus.flush_did_i);

    // Per-way tag compare for the lookup, fill and single-DID invalidate ports
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign lu_hit_vec[w]   = valid_q[lu_set][w] && (tag_q[lu_set][w] == lu_tag);
        assign up_match_vec[w] = valid_q[up_set][w] && (tag_q[up_set][w] == up_tag);
        assign fl_match_vec[w] = valid_q[fl_set][w] && (tag_q[fl_set][w] == fl_tag);
    end

    assign busy       = (state_q == WALK);
    assign ready      = !busy && !bus.flush_i;
    assign lu_accept  = bus.lookup_valid_i && ready;
    assign fill_en    = (state_q == IDLE) && !bus.flush_i && bus.update_i && bus.up_dc_v_i;
    assign lu_hit_way = enc(lu_hit_vec);

    // Fill target: existing copy of the tag, else lowest free way, else PLRU victim (pre-lookup tree)
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[up_set][w]) begin
                free_found = 1'b1;
                free_way   = way_t'(w);
            end
        end
        if (|up_match_vec)   fill_way = enc(up_match_vec);
        else if (free_found) fill_way = free_way;
        else                 fill_way = plru_victim(plru_q[up_set]);
    end

    // Next state: lookup response and hit touch, then fill / invalidate / walk step.
    // The fill touch is applied after the hit touch so it wins on shared nodes.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        plru_d       = plru_q;
        lu_valid_d   = 1'b0;
        lu_hit_d     = 1'b0;
        lu_content_d = '0;

        if (lu_accept) begin
            lu_valid_d = 1'b1;
            if (|lu_hit_vec) begin
                lu_hit_d         = 1'b1;
                lu_content_d     = data_q[lu_set][lu_hit_way];
                plru_d[lu_set]   = plru_touch(plru_d[lu_set], lu_hit_way);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.flush_i) begin
                    if (bus.flush_dv_i) begin
                        valid_d[fl_set] = valid_q[fl_set] & ~fl_match_vec;
                    end else begin
                        state_d = WALK;
                        cnt_d   = '0;
                    end
                end else if (fill_en) begin
                    valid_d[up_set][fill_way] = 1'b1;
                    plru_d[up_set]            = plru_touch(plru_d[up_set], fill_way);
                end
            end
            WALK: begin
                valid_d[cnt_q] = '0;
                plru_d[cnt_q]  = '0;
                if (cnt_q == idx_t'(SETS - 1)) state_d = IDLE;
                else                           cnt_d   = cnt_q + idx_t'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, valid bits, PLRU trees and response registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            valid_q      <= '0;
            plru_q       <= '0;
            lu_valid_q   <= 1'b0;
            lu_hit_q     <= 1'b0;
            lu_content_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            plru_q       <= plru_d;
            lu_valid_q   <= lu_valid_d;
            lu_hit_q     <= lu_hit_d;
            lu_content_q <= lu_content_d;
        end
    end

    // Tag/DC payload; qualified by valid bits so it needs no reset
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_q[up_set][fill_way]  <= up_tag;
            data_q[up_set][fill_way] <= bus.up_content_i;
        end
    end

    assign bus.lookup_ready_o = ready;
    assign bus.flush_busy_o   = busy;
    assign bus.lu_valid_o     = lu_valid_q;
    assign bus.lu_hit_o       = lu_hit_q;
    assign bus.lu_content_o   = lu_content_q;

`ifdef IOMMU_DDTC_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Saturating outcome counters, updated together with the response registers
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lu_valid_d) begin
            if (lu_hit_d && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_d  = hit_cnt_q + 32'd1;
            if (!lu_hit_d && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    // Counter registers; flushes leave them alone
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

    // Structural invariants: geometry, single hit, single resident copy per tag
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert ((SETS & (SETS - 1)) == 0);
            assert (((WAYS & (WAYS - 1)) == 0) && (WAYS >= 2));
            assert ($onehot0(lu_hit_vec));
            assert ($onehot0(up_match_vec));
            assert ($onehot0(fl_match_vec));
        end
    end
endmodule

// File: tb/tb_iommu_ddtc_sa.sv
// tb_iommu_ddtc_sa: directed + random stimulus against a recency-history model of the DDTC.
module tb_iommu_ddtc_sa;
    localparam int DW   = 24;
    localparam int CW   = 512;
    localparam int SETS = 4;
    localparam int WAYS = 4;
    localparam int LW   = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    iommu_ddtc_sa_if #(.DID_WIDTH(DW), .DC_WIDTH(CW)) bus ();
`ifdef IOMMU_DDTC_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    iommu_ddtc_sa #(.DID_WIDTH(DW), .DC_WIDTH(CW), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus)
`ifdef IOMMU_DDTC_PERF_CNT_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            cyc;
        logic [DW-1:0] did;
        bit            hit;
        logic [CW-1:0] dc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model: contents plus last-touch time per way (0 = untouched since reset/walk)
    bit            m_v   [SETS][WAYS];
    logic [DW-1:0] m_did [SETS][WAYS];
    logic [CW-1:0] m_dc  [SETS][WAYS];
    longint        m_ts  [SETS][WAYS];
    longint        tick;
    int            walk_left, walk_set;

    function automatic int find_way(input int s, input logic [DW-1:0] did);
        for (int w = 0; w < WAYS; w++)
            if (m_v[s][w] && m_did[s][w] == did) return w;
        return -1;
    endfunction

    // Victim bit l = inverse of bit l of the most recently touched way among those sharing
    // the already chosen low bits; 0 if none of them was touched.
    function automatic int victim(input int s);
        int v = 0;
        for (int l = 0; l < LW; l++) begin
            longint best = 0;
            int     bw   = -1;
            for (int w = 0; w < WAYS; w++)
                if ((w & ((1 << l) - 1)) == v && m_ts[s][w] > best) begin
                    best = m_ts[s][w];
                    bw   = w;
                end
            if (bw >= 0 && ((bw >> l) & 1) == 0) v = v | (1 << l);
        end
        return v;
    endfunction

    function automatic int pick_way(input int s, input logic [DW-1:0] did);
        int w = find_way(s, did);
        if (w >= 0) return w;
        for (int i = 0; i < WAYS; i++)
            if (!m_v[s][i]) return i;
        return victim(s);
    endfunction

    function automatic logic [CW-1:0] rand_dc();
        logic [CW-1:0] r;
        for (int i = 0; i < CW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Response monitor: one expected entry per accepted lookup, due in a specific cycle
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (!rst_i) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL lookup_missing did=%h due cyc %0d", e.did, e.cyc);
            end
            vectors++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                if (!(bus.lu_valid_o === 1'b1 && bus.lu_hit_o === e.hit && bus.lu_content_o === e.dc)) begin
                    miscompares++;
                    $display("FAIL lookup did=%h: got v=%b hit=%b dc=%h want hit=%b dc=%h",
                             e.did, bus.lu_valid_o, bus.lu_hit_o, bus.lu_content_o, e.hit, e.dc);
                end
            end else if (bus.lu_valid_o !== 1'b0 || bus.lu_hit_o !== 1'b0 || bus.lu_content_o !== '0) begin
                miscompares++;
                $display("FAIL idle_output cyc %0d: got v=%b hit=%b dc=%h want all zero",
                         cyc, bus.lu_valid_o, bus.lu_hit_o, bus.lu_content_o);
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at next posedge+1
    task automatic step(input bit lv, input logic [DW-1:0] ldid,
                        input bit up, input logic [DW-1:0] udid, input logic [CW-1:0] udc, input bit udv,
                        input bit fl, input bit fdv, input logic [DW-1:0] fdid);
        bit   busy, acc;
        int   ls, hw, us, fw;
        exp_t e;
        bus.lookup_valid_i = lv;   bus.lu_did_i    = ldid;
        bus.update_i       = up;   bus.up_did_i    = udid;
        bus.up_content_i   = udc;  bus.up_dc_v_i   = udv;
        bus.flush_i        = fl;   bus.flush_dv_i  = fdv;
        bus.flush_did_i    = fdid;
        #1;
        busy = (walk_left > 0);
        chk("flush_busy", CW'(bus.flush_busy_o), CW'(busy));
        chk("lookup_ready", CW'(bus.lookup_ready_o), CW'(!busy && !fl));
        acc = lv && !busy && !fl;
        ls  = int'(ldid) % SETS;
        hw  = acc ? find_way(ls, ldid) : -1;
        if (acc) begin
            e.cyc = cyc + 1;
            e.did = ldid;
            e.hit = (hw >= 0);
            e.dc  = '0;
            if (hw >= 0) e.dc = m_dc[ls][hw];
            exp_q.push_back(e);
        end
        us = int'(udid) % SETS;
        fw = -1;
        if (!busy && !fl && up && udv) fw = pick_way(us, udid);
        if (hw >= 0) begin
            tick++;
            m_ts[ls][hw] = tick;
        end
        if (busy) begin
            for (int w = 0; w < WAYS; w++) begin
                m_v[walk_set][w]  = 1'b0;
                m_ts[walk_set][w] = 0;
            end
            walk_set++;
            walk_left--;
        end else if (fl) begin
            if (fdv) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        if (m_v[s][w] && m_did[s][w] == fdid) m_v[s][w] = 1'b0;
            end else begin
                walk_left = SETS;
                walk_set  = 0;
            end
        end else if (fw >= 0) begin
            m_v[us][fw]   = 1'b1;
            m_did[us][fw] = udid;
            m_dc[us][fw]  = udc;
            tick++;
            m_ts[us][fw]  = tick;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0, 0, 0, '0);
    endtask

    task automatic lu(input logic [DW-1:0] did);
        step(1, did, 0, '0, '0, 0, 0, 0, '0);
    endtask

    task automatic fill(input logic [DW-1:0] did, input logic [CW-1:0] dc, input bit dv);
        step(0, '0, 1, did, dc, dv, 0, 0, '0);
    endtask

    task automatic flush(input bit dv, input logic [DW-1:0] did);
        step(0, '0, 0, '0, '0, 0, 1, dv, did);
    endtask

    // Asynchronous reset mid-cycle; checks reset outputs, then releases
    task automatic do_reset(input int hold);
        rst_i = 1'b1;
        bus.lookup_valid_i = 0; bus.update_i = 0; bus.flush_i = 0;
        bus.flush_dv_i = 0; bus.up_dc_v_i = 0;
        bus.lu_did_i = '0; bus.up_did_i = '0; bus.flush_did_i = '0; bus.up_content_i = '0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_v[s][w]  = 1'b0;
                m_ts[s][w] = 0;
            end
        tick = 0; walk_left = 0; walk_set = 0;
        exp_q.delete();
        #1;
        chk("rst_flush_busy", CW'(bus.flush_busy_o), '0);
        chk("rst_lu_valid", CW'(bus.lu_valid_o), '0);
        repeat (hold) @(posedge clk_i);
        #1;
        chk("rst_lu_hit", CW'(bus.lu_hit_o), '0);
        chk("rst_lu_content", bus.lu_content_o, '0);
`ifdef IOMMU_DDTC_PERF_CNT_EN
        chk("rst_hit_cnt", CW'(hit_cnt), '0);
        chk("rst_miss_cnt", CW'(miss_cnt), '0);
`endif
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready", CW'(bus.lookup_ready_o), CW'(1));
        chk("post_rst_busy", CW'(bus.flush_busy_o), '0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [CW-1:0] pa, pb;
        logic [DW-1:0] d;
        do_reset(3);
        pa = rand_dc();
        pb = rand_dc();

        // Basic hit / miss
        fill(24'h000005, pa, 1);
        lu(24'h000005);
        lu(24'h000006);

        // Set 0 fills, recency via lookups, then eviction by PLRU
        fill(24'h04, rand_dc(), 1); fill(24'h08, rand_dc(), 1);
        fill(24'h0C, rand_dc(), 1); fill(24'h10, rand_dc(), 1);
        lu(24'h04); lu(24'h08); lu(24'h0C);
        fill(24'h14, rand_dc(), 1);
        lu(24'h04); lu(24'h08); lu(24'h0C); lu(24'h10); lu(24'h14);

        // Refill of a resident tag overwrites in place
        fill(24'h04, pb, 1);
        lu(24'h04); lu(24'h08); lu(24'h0C); lu(24'h14);

        // Dropped fills: DC invalid, and flush in the same cycle
        fill(24'h20, rand_dc(), 0);
        lu(24'h20);
        step(0, '0, 1, 24'h24, rand_dc(), 1, 1, 1, 24'h30);
        lu(24'h24);

        // Single-DID invalidate
        flush(1, 24'h08);
        lu(24'h04); lu(24'h08); lu(24'h0C); lu(24'h14); lu(24'h05);

        // Same-cycle lookup and overwriting fill of the same entry: lookup sees old data
        step(1, 24'h04, 1, 24'h04, pa, 1, 0, 0, '0);
        lu(24'h04);

        // Invalidate-all walk with lookups pending against it
        flush(0, '0);
        for (int i = 0; i < SETS + 1; i++) lu(24'h04);
        lu(24'h05); lu(24'h14);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r = $urandom_range(0, 99);
            step($urandom_range(0, 1), DW'($urandom_range(0, 47)),
                 ($urandom_range(0, 2) == 0), DW'($urandom_range(0, 47)), rand_dc(),
                 ($urandom_range(0, 7) != 0),
                 (r < 3), (r != 0), DW'($urandom_range(0, 47)));
        end
        idle(2);

        // Reset while walking: sets not yet reached by the walk must also be empty
        for (int i = 0; i < 8; i++) begin
            d = DW'(i);
            fill(d, rand_dc(), 1);
        end
        flush(0, '0);
        idle(1);
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            d = DW'(i);
            lu(d);
        end
        idle(2);

`ifdef IOMMU_DDTC_PERF_CNT_EN
        do_reset(2);
        fill(24'h01, rand_dc(), 1); fill(24'h02, rand_dc(), 1); fill(24'h03, rand_dc(), 1);
        lu(24'h01); lu(24'h02); lu(24'h03); lu(24'h41); lu(24'h42);
        idle(2);
        chk("hit_cnt", CW'(hit_cnt), CW'(3));
        chk("miss_cnt", CW'(miss_cnt), CW'(2));
`endif

        idle(2);
        chk("pending_responses", CW'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/iommu_ddtc_sa.md
Name: iommu_ddtc_sa

Overview:
Parametrised, set-associative successor to the fully-associative Device Directory Table Cache in the RISC-V IOMMU. It caches extended Device Contexts indexed by device_id and keeps one PLRU tree per set. Lookup uses a valid/ready handshake with a registered (1-cycle) response. Invalidate-all is a multi-cycle set-walk sequencer. It sits between the IOMMU translation wrapper and the DDT walker.

Parameters:
DID_WIDTH, 24, device_id width in bits
DC_WIDTH, 512, cached Device Context width (extended DC format)
SETS, 4, number of sets; power of 2, >=1
WAYS, 4, ways per set; power of 2, >=2

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
lookup_valid_i  in  1  lookup request
lookup_ready_o  out  1  lookup can be accepted
lu_did_i  in  DID_WIDTH  device_id to look up
lu_valid_o  out  1  lookup result valid (1-cycle pulse)
lu_hit_o  out  1  hit; qualified by lu_valid_o
lu_content_o  out  DC_WIDTH  cached DC on hit, zero on miss
update_i  in  1  fill request from walker
up_did_i  in  DID_WIDTH  device_id to insert
up_content_i  in  DC_WIDTH  DC to insert
up_dc_v_i  in  1  DC valid bit (tc.v); fill only if 1
flush_i  in  1  IODIR.INVAL_DDT
flush_dv_i  in  1  1: single-DID invalidate, 0: invalidate all
flush_did_i  in  DID_WIDTH  device_id to invalidate
flush_busy_o  out  1  invalidate-all in progress

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Address split: set index = did[log2(SETS)-1:0] (0 bits if SETS=1); tag = the remaining upper bits.
- Reset: all valid bits 0, all PLRU trees 0, FSM IDLE, lu_valid_o=0, lu_hit_o=0, lu_content_o=0, flush_busy_o=0, lookup_ready_o=1 once reset is released.
- lookup_ready_o = !flush_busy_o && !flush_i.
- Lookup acceptance: a lookup is accepted in cycle N when lookup_valid_i && lookup_ready_o.
- Lookup response: in cycle N+1, lu_valid_o=1 and lu_hit_o/lu_content_o are registered from state as it was at cycle N.
- Back-to-back lookups are accepted every cycle. A lookup with no acceptance gives lu_valid_o=0 and lu_content_o=0.
- PLRU update on hit: at cycle N the set's tree is updated to point away from the hit way, using the same node encoding as the existing DDTC: node bit = ~(way bit at that level).
- Fill (update_i && up_dc_v_i, FSM IDLE, !flush_i):
  - If a valid way in the set already holds the tag, overwrite that way.
  - Otherwise use the lowest-index invalid way.
  - Otherwise use the PLRU victim.
  - The written way is marked MRU in the PLRU tree.
  - Fills with up_dc_v_i=0 are dropped.
- Same cycle, same set, lookup and fill: the lookup returns the pre-fill state. If both touch the PLRU, the fill's update wins.
- Flush DV=1: single cycle. Every valid way whose full did matches is invalidated. PLRU is untouched.
- Flush DV=0: FSM moves IDLE -> WALK.
  - A set counter runs 0..SETS-1, clearing one set's valid bits and PLRU tree per cycle.
  - flush_busy_o=1 from the cycle after flush_i through the last set. The FSM returns to IDLE after set SETS-1.
  - Total is SETS cycles busy.
- During WALK: flush_i and update_i are ignored (dropped); lookups are stalled.
- Priority when flush_i and update_i arrive together: flush wins and the fill is dropped.
- Reset mid-WALK: immediate return to IDLE with all entries invalid.
- Assertions: at most one hit way per set; at most one victim per set; SETS and WAYS are powers of 2.

Optional Feature:
IOMMU_DDTC_PERF_CNT_EN
- Defined: adds ports hit_cnt_o and miss_cnt_o (out, 32 bits each).
  - Counts accepted lookups by outcome, incrementing in the response cycle.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
  - Flushes do not clear them.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Fill did=0x000005 with DC=pattern A, then look up 0x000005 -> next cycle lu_valid_o=1, lu_hit_o=1, content=A. Look up 0x000006 -> lu_hit_o=0, content=0.
- SETS=4, WAYS=4: fill did 0x04,0x08,0x0C,0x10 (set 0), then look up 0x04, 0x08 and 0x0C, then fill 0x14 -> way holding 0x10 evicted. 0x04, 0x08 and 0x0C still hit; 0x10 misses.
- Refill 0x04 with DC=B while it is cached -> same way overwritten, no duplicate; the lookup returns B and the set's other entries still hit.
- Fill with up_dc_v_i=0 -> no entry written; lookup misses. Fill while flush_i=1 -> dropped.
- Flush DV=1 did=0x08 -> only 0x08 misses afterwards. Flush DV=0 -> flush_busy_o high exactly 4 cycles and lookup_ready_o low; afterwards all entries miss.
- Assert rst_i during WALK, then release -> flush_busy_o=0, lookup_ready_o=1, all lookups miss. With IOMMU_DDTC_PERF_CNT_EN: 3 hits + 2 misses -> hit_cnt_o=3, miss_cnt_o=2.
